// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
//   state_t      : operation phase (LOAD_A, LOAD_B, COMPUTE, OUTPUT)
//   acc_width()  : full-precision accumulator width, 2*DATA_W + clog2(N)
//   sat_convert(): clamps an extended accumulator value into an OUT_W range
package matmul_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    // Working width for the saturation helper; callers extend into it.
    localparam int unsigned MAX_W = 128;

    typedef struct packed {
        logic             sat;
        logic [MAX_W-1:0] val;
    } cvt_t;

    function automatic int unsigned acc_width(input int unsigned n, input int unsigned data_w);
        return 2 * data_w + 32'($clog2(n));
    endfunction

    // acc_ext must already be sign- or zero-extended to MAX_W.
    // The low out_w bits of val hold the clamped (or unchanged) result.
    function automatic cvt_t sat_convert(input logic [MAX_W-1:0] acc_ext,
                                         input int unsigned      out_w,
                                         input bit               is_signed);
        cvt_t             r;
        logic [MAX_W-1:0] one;
        logic [MAX_W-1:0] umax;
        logic [MAX_W-1:0] smax;
        logic [MAX_W-1:0] smin;
        one   = MAX_W'(1);
        umax  = (one << out_w) - one;
        smax  = (one << (out_w - 1)) - one;
        smin  = ~smax;
        r.sat = 1'b0;
        r.val = acc_ext;
        if (is_signed) begin
            if ($signed(acc_ext) > $signed(smax)) begin
                r.sat = 1'b1;
                r.val = smax;
            end else if ($signed(acc_ext) < $signed(smin)) begin
                r.sat = 1'b1;
                r.val = smin;
            end
        end else if ((acc_ext & ~umax) != '0) begin
            r.sat = 1'b1;
            r.val = umax;
        end
        return r;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate: o_acc <= (i_clr ? 0 : o_acc) + i_a*i_b when i_en.
// Ports: clk, rst_n (sync, active-low), i_en, i_clr, i_a/i_b operands, o_acc.
// SIGNED selects two's-complement or unsigned extension of the product.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 34,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [ACC_W-1:0] w_prod;
    logic [ACC_W-1:0] r_acc;

    // Product extended to the accumulator width according to signedness.
    generate
        if (SIGNED) begin : g_signed
            logic signed [PROD_W-1:0] w_sprod;
            assign w_sprod = PROD_W'($signed(i_a)) * PROD_W'($signed(i_b));
            assign w_prod  = ACC_W'(w_sprod);
        end else begin : g_unsigned
            logic [PROD_W-1:0] w_uprod;
            assign w_uprod = PROD_W'(i_a) * PROD_W'(i_b);
            assign w_prod  = ACC_W'(w_uprod);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_clr ? '0 : r_acc) + w_prod;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN matrix multiplier, C = A x B, sharing one MAC.
// Operands stream in row-major (A then B) over in_valid/in_ready/in_data;
// results stream out row-major over out_valid/out_ready/out_data with out_last
// on C[N-1][N-1]. busy is high except in LOAD_A before the first beat.
// ovf is a sticky per-operation saturation flag.
// Optional build macro MATMUL_SAT_EN: saturate results to OUT_W and drive ovf;
// without it results wrap to the low OUT_W bits and ovf is 0.
// Reset rst_n is synchronous, active-low.
module matrix_mult_seq
    import matmul_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned ACC_W = acc_width(N, DATA_W);
    localparam int unsigned NN    = N * N;
    localparam int unsigned IDX_W = $clog2(NN);
    localparam int unsigned LP_W  = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [LP_W-1:0]  LAST_LP  = LP_W'(N - 1);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_busy;
    logic [OUT_W-1:0]  r_out_data;
    logic [IDX_W-1:0]  r_in_cnt;
    logic [IDX_W-1:0]  r_out_idx;
    logic [LP_W-1:0]   r_i;
    logic [LP_W-1:0]   r_j;
    logic [LP_W-1:0]   r_k;
    logic              r_wr_pend;
    logic [IDX_W-1:0]  r_wr_idx;

    logic [DATA_W-1:0] r_a [NN];
    logic [DATA_W-1:0] r_b [NN];
    logic [OUT_W-1:0]  r_c [NN];

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_mac_en;
    logic              w_mac_clr;
    logic [IDX_W-1:0]  w_a_idx;
    logic [IDX_W-1:0]  w_b_idx;
    logic [IDX_W-1:0]  w_c_idx;
    logic [IDX_W-1:0]  w_out_nxt;
    logic [ACC_W-1:0]  w_acc;
    logic [OUT_W-1:0]  w_c_val;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_mac_en   = (r_state == COMPUTE);
    assign w_mac_clr  = (r_k == '0);
    assign w_a_idx    = IDX_W'(32'(r_i) * N + 32'(r_k));
    assign w_b_idx    = IDX_W'(32'(r_k) * N + 32'(r_j));
    assign w_c_idx    = IDX_W'(32'(r_i) * N + 32'(r_j));
    assign w_out_nxt  = r_out_idx + IDX_W'(1);

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_mac_en),
        .i_clr (w_mac_clr),
        .i_a   (r_a[w_a_idx]),
        .i_b   (r_b[w_b_idx]),
        .o_acc (w_acc)
    );

`ifdef MATMUL_SAT_EN
    logic [MAX_W-1:0] w_acc_ext;
    cvt_t             w_cvt;
    logic             w_unused_hi;
    logic             r_ovf;

    // Extend the accumulator, then clamp into the OUT_W range.
    always_comb begin
        if (SIGNED) begin
            w_acc_ext = MAX_W'($signed(w_acc));
        end else begin
            w_acc_ext = MAX_W'(w_acc);
        end
        w_cvt   = sat_convert(w_acc_ext, OUT_W, SIGNED);
        w_c_val = OUT_W'(w_cvt.val);
    end

    assign w_unused_hi = ^w_cvt.val[MAX_W-1:OUT_W];

    // Sticky until the operation's final output handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_out_fire && r_out_last) begin
            r_ovf <= 1'b0;
        end else if (r_wr_pend && w_cvt.sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    // Wrap-around: keep the low OUT_W bits (extended if OUT_W is wider).
    always_comb begin
        if (SIGNED) begin
            w_c_val = OUT_W'($signed(w_acc));
        end else begin
            w_c_val = OUT_W'(w_acc);
        end
    end

    assign ovf = 1'b0;
`endif

    // Operand and result buffers; no reset needed, counters gate their use.
    always_ff @(posedge clk) begin
        if (w_in_fire && (r_state == LOAD_A)) begin
            r_a[r_in_cnt] <= in_data;
        end
        if (w_in_fire && (r_state == LOAD_B)) begin
            r_b[r_in_cnt] <= in_data;
        end
        if (r_wr_pend) begin
            r_c[r_wr_idx] <= w_c_val;
        end
    end

    // Control FSM with registered outputs.
    // The MAC result lands one cycle after the k==N-1 issue, so C writes are
    // delayed by one cycle; OUTPUT spends its first cycle letting the last
    // write settle before presenting C[0][0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= LOAD_A;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
            r_in_cnt    <= '0;
            r_out_idx   <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_wr_pend   <= 1'b0;
            r_wr_idx    <= '0;
        end else begin
            r_wr_pend <= (r_state == COMPUTE) && (r_k == LAST_LP);
            r_wr_idx  <= w_c_idx;
            unique case (r_state)
                LOAD_A: begin
                    if (w_in_fire) begin
                        r_busy <= 1'b1;
                        if (r_in_cnt == LAST_IDX) begin
                            r_in_cnt <= '0;
                            r_state  <= LOAD_B;
                        end else begin
                            r_in_cnt <= r_in_cnt + IDX_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (w_in_fire) begin
                        if (r_in_cnt == LAST_IDX) begin
                            r_in_cnt   <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= COMPUTE;
                        end else begin
                            r_in_cnt <= r_in_cnt + IDX_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (r_k == LAST_LP) begin
                        r_k <= '0;
                        if (r_j == LAST_LP) begin
                            r_j <= '0;
                            if (r_i == LAST_LP) begin
                                r_i     <= '0;
                                r_state <= OUTPUT;
                            end else begin
                                r_i <= r_i + LP_W'(1);
                            end
                        end else begin
                            r_j <= r_j + LP_W'(1);
                        end
                    end else begin
                        r_k <= r_k + LP_W'(1);
                    end
                end
                OUTPUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_c[0];
                        r_out_idx   <= '0;
                        r_out_last  <= 1'b0;
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= LOAD_A;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b0;
                            r_out_idx   <= '0;
                        end else begin
                            r_out_idx  <= w_out_nxt;
                            r_out_data <= r_c[w_out_nxt];
                            r_out_last <= (w_out_nxt == LAST_IDX);
                        end
                    end
                end
                default: r_state <= LOAD_A;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: three instances (3x3 unsigned, 3x3 signed,
// 4x4 8-bit unsigned) share stimulus; sel picks the one under test.
module tb_matrix_mult_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    int          sel;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic v0, v1, v2;
    assign v0 = in_valid && (sel == 0);
    assign v1 = in_valid && (sel == 1);
    assign v2 = in_valid && (sel == 2);

    logic        r0_ir, r0_ov, r0_ol, r0_bz, r0_of;
    logic        r1_ir, r1_ov, r1_ol, r1_bz, r1_of;
    logic        r2_ir, r2_ov, r2_ol, r2_bz, r2_of;
    logic [31:0] r0_od, r1_od, r2_od;

    matrix_mult_seq #(.N(3), .DATA_W(16), .OUT_W(32), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0_ir), .in_data(in_data),
        .out_valid(r0_ov), .out_ready(out_ready), .out_data(r0_od), .out_last(r0_ol),
        .busy(r0_bz), .ovf(r0_of));

    matrix_mult_seq #(.N(3), .DATA_W(16), .OUT_W(32), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1_ir), .in_data(in_data),
        .out_valid(r1_ov), .out_ready(out_ready), .out_data(r1_od), .out_last(r1_ol),
        .busy(r1_bz), .ovf(r1_of));

    matrix_mult_seq #(.N(4), .DATA_W(8), .OUT_W(32), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2_ir), .in_data(in_data[7:0]),
        .out_valid(r2_ov), .out_ready(out_ready), .out_data(r2_od), .out_last(r2_ol),
        .busy(r2_bz), .ovf(r2_of));

    logic        m_ir, m_ov, m_ol, m_bz, m_of;
    logic [31:0] m_od;

    always_comb begin
        case (sel)
            1: begin m_ir = r1_ir; m_ov = r1_ov; m_ol = r1_ol; m_bz = r1_bz; m_of = r1_of; m_od = r1_od; end
            2: begin m_ir = r2_ir; m_ov = r2_ov; m_ol = r2_ol; m_bz = r2_bz; m_of = r2_of; m_od = r2_od; end
            default: begin m_ir = r0_ir; m_ov = r0_ov; m_ol = r0_ol; m_bz = r0_bz; m_of = r0_of; m_od = r0_od; end
        endcase
    end

    // Operation stimulus, reference results and captured outputs.
    logic [15:0] op_a [16];
    logic [15:0] op_b [16];
    logic [31:0] exp_c [16];
    bit          exp_sat;
    logic [31:0] got_d [16];
    logic        got_l [16];
    int          got_n;
    logic        got_ovf;
    int          first_f, last_f, first_v, last_hs, stall_err, rdy_err, ovf_unst;
    bit          to_in, to_out;

    function automatic longint ext(input logic [15:0] x, input int dw, input bit sgn);
        longint v;
        longint m;
        m = (longint'(1) << dw) - 1;
        v = longint'({48'd0, x}) & m;
        if (sgn && v[dw-1]) v = v - (longint'(1) << dw);
        return v;
    endfunction

    // C = A x B with plain integer arithmetic, then fit into 32 bits.
    function automatic void model(input int n, input int dw, input bit sgn);
        longint s;
        exp_sat = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s = s + ext(op_a[i*n+k], dw, sgn) * ext(op_b[k*n+j], dw, sgn);
`ifdef MATMUL_SAT_EN
                if (!sgn && s > longint'(64'h00000000FFFFFFFF)) begin
                    s = longint'(64'h00000000FFFFFFFF); exp_sat = 1'b1;
                end else if (sgn && s > longint'(64'h000000007FFFFFFF)) begin
                    s = longint'(64'h000000007FFFFFFF); exp_sat = 1'b1;
                end else if (sgn && s < -longint'(64'h0000000080000000)) begin
                    s = -longint'(64'h0000000080000000); exp_sat = 1'b1;
                end
`endif
                exp_c[i*n+j] = s[31:0];
            end
        end
    endfunction

    function automatic void rand_op(input int n, input int dw);
        for (int i = 0; i < n*n; i++) begin
            op_a[i] = 16'($urandom_range((1 << dw) - 1));
            op_b[i] = 16'($urandom_range((1 << dw) - 1));
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Streams A then B; records cycle numbers of the first and last accepted beats.
    task automatic send_op(input int n, input int gap_pct);
        int idx;
        int guard;
        bit fire;
        idx = 0; guard = 0; first_f = -1; last_f = -1; to_in = 1'b0;
        while (idx < 2*n*n) begin
            if (guard > 4000) begin to_in = 1'b1; break; end
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = (idx < n*n) ? op_a[idx] : op_b[idx - n*n];
            fire     = in_valid && m_ir;
            @(posedge clk); #1; guard++;
            if (fire) begin
                if (first_f < 0) first_f = cyc;
                last_f = cyc;
                idx++;
            end
        end
        in_valid = 1'b0;
    endtask

    // Collects N*N results with random out_ready, tracking stall stability and in_ready.
    task automatic collect(input int n, input int rdy_pct);
        int guard;
        bit fire, stalled;
        logic [31:0] pd;
        logic pl;
        guard = 0; stalled = 1'b0; got_n = 0; first_v = -1; last_hs = -1;
        stall_err = 0; rdy_err = 0; ovf_unst = 0; to_out = 1'b0; got_ovf = 1'b0;
        while (got_n < n*n) begin
            if (guard > 4000) begin to_out = 1'b1; break; end
            if (stalled && (!m_ov || m_od !== pd || m_ol !== pl)) stall_err++;
            if (m_ir) rdy_err++;
            out_ready = ($urandom_range(99) < rdy_pct);
            fire      = m_ov && out_ready;
            stalled   = m_ov && !out_ready;
            pd = m_od; pl = m_ol;
            if (m_ov) begin
                if (first_v < 0) begin first_v = cyc; got_ovf = m_of; end
                else if (m_of !== got_ovf) ovf_unst++;
            end
            if (fire) begin got_d[got_n] = m_od; got_l[got_n] = m_ol; got_n++; end
            @(posedge clk); #1; guard++;
            if (fire && got_n == n*n) last_hs = cyc;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        checks++; if (m_ir !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", m_ir); end
        checks++; if (m_ov !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", m_ov); end
        checks++; if (m_ol !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %b want 0", m_ol); end
        checks++; if (m_bz !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", m_bz); end
        checks++; if (m_of !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b want 0", m_of); end
        checks++; if (m_od !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", m_od); end
        in_valid = 1'b1; in_data = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (m_bz !== 1'b1) begin errors++; $display("FAIL busy_after_beat: got %b want 1", m_bz); end
        checks++; if (m_ir !== 1'b1) begin errors++; $display("FAIL ready_after_beat: got %b want 1", m_ir); end
        do_reset();
    endtask

    task automatic test_identity();
        sel = 0;
        for (int i = 0; i < 9; i++) begin
            op_a[i] = ((i / 3) == (i % 3)) ? 16'd1 : 16'd0;
            op_b[i] = 16'(i + 1);
        end
        send_op(3, 0);
        collect(3, 100);
        checks++; if (to_in || to_out) begin errors++; $display("FAIL identity_timeout: in=%b out=%b want 0/0", to_in, to_out); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got_d[i] !== 32'(i + 1)) begin errors++; $display("FAIL identity_c[%0d]: got %h want %h", i, got_d[i], 32'(i + 1)); end
            checks++; if (got_l[i] !== (i == 8)) begin errors++; $display("FAIL identity_last[%0d]: got %b want %b", i, got_l[i], (i == 8)); end
        end
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL identity_ovf: got %b want 0", got_ovf); end
        checks++; if (first_v - last_f != 28) begin errors++; $display("FAIL identity_latency: got %0d want 28", first_v - last_f); end
        checks++; if (rdy_err != 0) begin errors++; $display("FAIL identity_in_ready_busy: got %0d high cycles want 0", rdy_err); end
    endtask

    task automatic test_all_max();
        sel = 0;
        for (int i = 0; i < 9; i++) begin op_a[i] = 16'hFFFF; op_b[i] = 16'hFFFF; end
        model(3, 16, 1'b0);
        send_op(3, 0);
        collect(3, 100);
        checks++; if (to_in || to_out) begin errors++; $display("FAIL allmax_timeout: in=%b out=%b want 0/0", to_in, to_out); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got_d[i] !== exp_c[i]) begin errors++; $display("FAIL allmax_c[%0d]: got %h want %h", i, got_d[i], exp_c[i]); end
        end
        checks++; if (got_ovf !== exp_sat) begin errors++; $display("FAIL allmax_ovf: got %b want %b", got_ovf, exp_sat); end
        checks++; if (ovf_unst != 0) begin errors++; $display("FAIL allmax_ovf_stable: got %0d changes want 0", ovf_unst); end
        checks++; if (m_of !== 1'b0) begin errors++; $display("FAIL allmax_ovf_clear: got %b want 0", m_of); end
    endtask

    task automatic test_signed_neg();
        sel = 1;
        for (int i = 0; i < 9; i++) begin
            op_a[i] = ((i / 3) == (i % 3)) ? 16'hFFFF : 16'h0000;
            op_b[i] = 16'(i + 1);
        end
        send_op(3, 0);
        collect(3, 100);
        checks++; if (to_in || to_out) begin errors++; $display("FAIL signed_timeout: in=%b out=%b want 0/0", to_in, to_out); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got_d[i] !== -32'(i + 1)) begin errors++; $display("FAIL signed_c[%0d]: got %h want %h", i, got_d[i], -32'(i + 1)); end
        end
        checks++; if (got_ovf !== 1'b0) begin errors++; $display("FAIL signed_ovf: got %b want 0", got_ovf); end
    endtask

    task automatic test_backpressure();
        for (int t = 0; t < 4; t++) begin
            sel = t % 2;
            rand_op(3, 16);
            model(3, 16, (sel == 1));
            send_op(3, 30);
            collect(3, 30);
            checks++; if (to_in || to_out) begin errors++; $display("FAIL bp_timeout[%0d]: in=%b out=%b want 0/0", t, to_in, to_out); end
            for (int i = 0; i < 9; i++) begin
                checks++; if (got_d[i] !== exp_c[i]) begin errors++; $display("FAIL bp_c[%0d][%0d]: got %h want %h", t, i, got_d[i], exp_c[i]); end
            end
            checks++; if (got_l[8] !== 1'b1) begin errors++; $display("FAIL bp_last[%0d]: got %b want 1", t, got_l[8]); end
            checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable[%0d]: got %0d changes want 0", t, stall_err); end
            checks++; if (rdy_err != 0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0d high cycles want 0", t, rdy_err); end
            checks++; if (got_ovf !== exp_sat) begin errors++; $display("FAIL bp_ovf[%0d]: got %b want %b", t, got_ovf, exp_sat); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        sel = 0;
        rand_op(3, 16);
        send_op(3, 0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (m_ir !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", m_ir); end
        checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", m_ov); end
        checks++; if (m_bz !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", m_bz); end
        seen = 0;
        out_ready = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (m_ov) seen++; end
        out_ready = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_output: got %0d valid cycles want 0", seen); end
        rand_op(3, 16);
        model(3, 16, 1'b0);
        send_op(3, 10);
        collect(3, 60);
        checks++; if (to_in || to_out) begin errors++; $display("FAIL rstmid_timeout: in=%b out=%b want 0/0", to_in, to_out); end
        for (int i = 0; i < 9; i++) begin
            checks++; if (got_d[i] !== exp_c[i]) begin errors++; $display("FAIL rstmid_c[%0d]: got %h want %h", i, got_d[i], exp_c[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int hs;
        sel = 2;
        do_reset();
        rand_op(4, 8);
        model(4, 8, 1'b0);
        send_op(4, 0);
        collect(4, 100);
        checks++; if (to_in || to_out) begin errors++; $display("FAIL b2b1_timeout: in=%b out=%b want 0/0", to_in, to_out); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_d[i] !== exp_c[i]) begin errors++; $display("FAIL b2b1_c[%0d]: got %h want %h", i, got_d[i], exp_c[i]); end
        end
        checks++; if (got_l[15] !== 1'b1) begin errors++; $display("FAIL b2b1_last: got %b want 1", got_l[15]); end
        checks++; if (first_v - last_f != 65) begin errors++; $display("FAIL b2b1_latency: got %0d want 65", first_v - last_f); end
        checks++; if (m_ov !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", m_ov); end
        checks++; if (m_ir !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b want 1", m_ir); end
        hs = last_hs;
        rand_op(4, 8);
        model(4, 8, 1'b0);
        send_op(4, 0);
        checks++; if (first_f != hs + 1) begin errors++; $display("FAIL b2b_first_accept: got cycle %0d want %0d", first_f, hs + 1); end
        collect(4, 50);
        checks++; if (to_in || to_out) begin errors++; $display("FAIL b2b2_timeout: in=%b out=%b want 0/0", to_in, to_out); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (got_d[i] !== exp_c[i]) begin errors++; $display("FAIL b2b2_c[%0d]: got %h want %h", i, got_d[i], exp_c[i]); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL b2b2_stall_stable: got %0d changes want 0", stall_err); end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_identity();
        test_all_max();
        test_signed_neg();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
